// File: rtl/axi4l_ram_responder_if.sv
// Bus interfaces for the AXI4-Lite responder: the AXI4-Lite slave port and
// the simple request/valid RAM port.
interface AXI4bus #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4
);
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface RAMbus #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4
);
  logic          req;
  logic          we;
  logic [SW-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  rvalid, rdata
  );
  modport slave (
    input  req, we, be, addr, wdata,
    output rvalid, rdata
  );
endinterface

// File: rtl/axi4l_ram_responder.sv
// AXI4-Lite responder that turns each accepted read or write into a single
// RAM request, one transaction in flight, with decode errors and a RAM timeout.
module axi4l_ram_responder #(
  parameter int            DW        = 32,
  parameter int            AW        = 32,
  parameter int            SW        = 4,
  parameter logic [AW-1:0] ADDR_BASE = 'h1000,
  parameter logic [AW-1:0] ADDR_SIZE = 'h1000,
  parameter int            TIMEOUT   = 16
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  AXI4bus.slave  s_axi,
  RAMbus.master  ram
);
  localparam int         CW     = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, W_WAIT, W_RESP, R_WAIT, R_RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          last_rd_reg;
  logic          req_reg, we_reg;
  logic [SW-1:0] be_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg, rdata_reg;
  logic [1:0]    bresp_reg, rresp_reg;

  logic          in_idle, wr_cand, rd_cand, wr_go, rd_go;
  logic          wr_hit, rd_hit, timed_out;
  logic [AW-1:0] wr_off, rd_off;

  assign in_idle = (state_reg == IDLE);
  assign wr_cand = s_axi.awvalid & s_axi.wvalid;
  assign rd_cand = s_axi.arvalid;
  // Round-robin: a contested cycle goes to whichever side was not served last.
  assign wr_go   = in_idle & rst_ni & wr_cand & (~rd_cand | last_rd_reg);
  assign rd_go   = in_idle & rst_ni & rd_cand & ~(wr_cand & last_rd_reg);

  assign wr_off    = s_axi.awaddr - ADDR_BASE;
  assign rd_off    = s_axi.araddr - ADDR_BASE;
  assign wr_hit    = (s_axi.awaddr >= ADDR_BASE) && (wr_off < ADDR_SIZE);
  assign rd_hit    = (s_axi.araddr >= ADDR_BASE) && (rd_off < ADDR_SIZE);
  assign timed_out = (cnt_reg == CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (wr_go)      state_next = wr_hit ? W_WAIT : W_RESP;
        else if (rd_go) state_next = rd_hit ? R_WAIT : R_RESP;
      end
      W_WAIT:  if (ram.rvalid || timed_out) state_next = W_RESP;
      W_RESP:  if (s_axi.bready)            state_next = IDLE;
      R_WAIT:  if (ram.rvalid || timed_out) state_next = R_RESP;
      R_RESP:  if (s_axi.rready)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = wr_go;
    s_axi.wready  = wr_go;
    s_axi.arready = rd_go;
    s_axi.bvalid  = (state_reg == W_RESP);
    s_axi.rvalid  = (state_reg == R_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg     <= '0;
      last_rd_reg <= 1'b1;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      be_reg      <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      bresp_reg   <= OKAY;
      rresp_reg   <= OKAY;
    end else begin
      req_reg <= 1'b0;
      if (state_reg == W_WAIT || state_reg == R_WAIT) cnt_reg <= cnt_reg + 1'b1;

      if (wr_go) begin
        last_rd_reg <= 1'b0;
        if (wr_hit) begin
          req_reg   <= 1'b1;
          we_reg    <= 1'b1;
          be_reg    <= s_axi.wstrb;
          addr_reg  <= wr_off & ~AW'(3);
          wdata_reg <= s_axi.wdata;
          cnt_reg   <= '0;
        end else begin
          bresp_reg <= SLVERR;
        end
      end else if (rd_go) begin
        last_rd_reg <= 1'b1;
        if (rd_hit) begin
          req_reg  <= 1'b1;
          we_reg   <= 1'b0;
          be_reg   <= '1;
          addr_reg <= rd_off & ~AW'(3);
          cnt_reg  <= '0;
        end else begin
          rresp_reg <= SLVERR;
          rdata_reg <= '0;
        end
      end

      // rvalid is only meaningful while waiting; a late one elsewhere is dropped.
      if (state_reg == W_WAIT) begin
        if (ram.rvalid)     bresp_reg <= OKAY;
        else if (timed_out) bresp_reg <= SLVERR;
      end
      if (state_reg == R_WAIT) begin
        if (ram.rvalid) begin
          rdata_reg <= ram.rdata;
          rresp_reg <= OKAY;
        end else if (timed_out) begin
          rdata_reg <= '0;
          rresp_reg <= SLVERR;
        end
      end
    end
  end

  assign s_axi.bresp = bresp_reg;
  assign s_axi.rresp = rresp_reg;
  assign s_axi.rdata = rdata_reg;
  assign ram.req     = req_reg;
  assign ram.we      = we_reg;
  assign ram.be      = be_reg;
  assign ram.addr    = addr_reg;
  assign ram.wdata   = wdata_reg;
endmodule

// File: tb/tb_axi4l_ram_responder.sv
// Randomised bench for axi4l_ram_responder: a behavioural RAM with programmable
// latency and a word-array reference model of the decoded window.
module tb_axi4l_ram_responder;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI4bus #(.DW(32), .AW(32), .SW(4)) s_if ();
  RAMbus  #(.DW(32), .AW(32), .SW(4)) ram_if ();

  axi4l_ram_responder #(
    .DW(32), .AW(32), .SW(4),
    .ADDR_BASE(32'h1000), .ADDR_SIZE(32'h1000), .TIMEOUT(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .s_axi (s_if),
    .ram   (ram_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word contents of the decoded window, unwritten words read 0.
  logic [31:0] ref_mem [int];

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h2000);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int k;
    k = int'((a - 32'h1000) >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ref_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[int'((a - 32'h1000) >> 2)] = w;
  endfunction

  // Behavioural RAM: answers each req with one rvalid after ram_lat cycles.
  logic [31:0] ram_mem [int];
  int          ram_lat  = 1;
  bit          ram_mute = 1'b0;
  int          ram_cd   = 0;
  logic [31:0] ram_pend;
  int          req_count = 0;
  int          last_req_cyc = -1;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  initial begin
    int          k;
    logic [31:0] w;
    ram_if.rvalid = 1'b0;
    ram_if.rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      ram_if.rvalid = 1'b0;
      ram_if.rdata  = $urandom;
      if (ram_cd > 0) begin
        ram_cd--;
        if (ram_cd == 0) begin
          ram_if.rvalid = 1'b1;
          ram_if.rdata  = ram_pend;
        end
      end
      if (ram_if.req) begin
        req_count++;
        last_req_cyc = cyc;
        last_addr    = ram_if.addr;
        last_be      = ram_if.be;
        last_we      = ram_if.we;
        last_wdata   = ram_if.wdata;
        k = int'(ram_if.addr >> 2);
        w = ram_mem.exists(k) ? ram_mem[k] : 32'h0;
        if (ram_if.we) begin
          for (int b = 0; b < 4; b++) if (ram_if.be[b]) w[b*8 +: 8] = ram_if.wdata[b*8 +: 8];
          ram_mem[k] = w;
          ram_pend   = 32'h0;
        end else begin
          ram_pend = w;
        end
        if (!ram_mute) ram_cd = ram_lat;
      end
    end
  end

  // Drives one AXI transaction and waits for its response to appear.
  task automatic axi_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int l,
                         output logic [1:0] resp, output logic [31:0] rd,
                         output int lat, output int t0);
    int n;
    @(negedge clk);
    ram_lat = l;
    if (wr) begin
      s_if.awaddr = a; s_if.wdata = d; s_if.wstrb = s;
      s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    end else begin
      s_if.araddr = a; s_if.arvalid = 1'b1;
    end
    #1;
    n = 0;
    while (!(wr ? s_if.awready : s_if.arready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_bound addr=%h got=no_ready want=ready", a);
    end
    t0 = cyc;
    @(negedge clk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    #1;
    n = 0;
    while (!(wr ? s_if.bvalid : s_if.rvalid) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL resp_bound addr=%h got=no_valid want=valid", a);
    end
    lat  = cyc - t0;
    resp = wr ? s_if.bresp : s_if.rresp;
    rd   = s_if.rdata;
  endtask

  task automatic test_reset;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
    s_if.awaddr = 32'h1000; s_if.araddr = 32'h1000;
    s_if.wdata = 32'h0; s_if.wstrb = 4'h0;
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_handshake got=%b want=00000",
               {s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid});
    end
    total++;
    if ({ram_if.req, ram_if.we} !== 2'b00 || ram_if.be !== 4'h0) begin
      bad++;
      $display("FAIL reset_ram_ctrl got=req%b we%b be%h want=0", ram_if.req, ram_if.we, ram_if.be);
    end
    total++;
    if (ram_if.addr !== 32'h0 || ram_if.wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_ram_data got=%h/%h want=0/0", ram_if.addr, ram_if.wdata);
    end
    total++;
    if (s_if.bresp !== 2'b00 || s_if.rresp !== 2'b00 || s_if.rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_resp got=%b/%b/%h want=00/00/0", s_if.bresp, s_if.rresp, s_if.rdata);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] wa, wd;
    string       order;
    int          acc_cyc[$];
    int          acc, rdone, n;
    wa = 32'h1000 + ($urandom_range(0, 1023) << 2);
    wd = $urandom;
    s_if.awaddr = wa; s_if.wdata = wd; s_if.wstrb = 4'hF; s_if.araddr = wa;
    ram_lat = 1; order = ""; acc = 0; rdone = 0; n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while ((acc < 4 || rdone < 2) && n < 200) begin
      #1;
      if (s_if.awready && s_if.wready) begin
        acc++; order = {order, "W"}; acc_cyc.push_back(cyc); ref_wr(wa, wd, 4'hF);
      end
      if (s_if.arready) begin
        acc++; order = {order, "R"}; acc_cyc.push_back(cyc);
      end
      if (s_if.bvalid) begin
        total++;
        if (s_if.bresp !== 2'b00) begin
          bad++; $display("FAIL arb_bresp got=%b want=00", s_if.bresp);
        end
      end
      if (s_if.rvalid) begin
        rdone++;
        total++;
        if (s_if.rdata !== ref_rd(wa) || s_if.rresp !== 2'b00) begin
          bad++;
          $display("FAIL arb_rdata got=%h/%b want=%h/00", s_if.rdata, s_if.rresp, ref_rd(wa));
        end
      end
      @(negedge clk);
      n++;
      if (acc >= 4) begin
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
      end
    end
    total++;
    if (n >= 200) begin
      bad++; $display("FAIL arb_bound got=%0d_accepts want=4", acc);
    end
    total++;
    if (order != "WRWR") begin
      bad++; $display("FAIL arb_order got=%s want=WRWR", order);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
        bad++; $display("FAIL arb_spacing idx=%0d got=%0d want=4", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    $display("arbitration order=%s", order);
  endtask

  task automatic test_write_read;
    logic [1:0]  resp;
    logic [31:0] rd, rd0;
    int          lat, t0, rc0;
    rc0 = req_count;
    axi_txn(1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, 1, resp, rd, lat, t0);
    ref_wr(32'h1010, 32'hDEADBEEF, 4'hF);
    $display("write addr=00001010 resp=%b lat=%0d", resp, lat);
    total++;
    if (lat != 3 || resp !== 2'b00) begin
      bad++; $display("FAIL wr_resp got=lat%0d/%b want=lat3/00", lat, resp);
    end
    total++;
    if (req_count - rc0 != 1 || last_req_cyc != t0 + 1) begin
      bad++;
      $display("FAIL wr_req got=n%0d@%0d want=n1@%0d", req_count - rc0, last_req_cyc, t0 + 1);
    end
    total++;
    if (last_addr !== 32'h10 || last_be !== 4'hF || last_we !== 1'b1 || last_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_ram_fields got=%h/%h/%b/%h want=00000010/f/1/deadbeef",
               last_addr, last_be, last_we, last_wdata);
    end
    total++;
    if (ram_if.addr !== 32'h10) begin
      bad++; $display("FAIL wr_addr_hold got=%h want=00000010", ram_if.addr);
    end

    s_if.rready = 1'b0;
    rc0 = req_count;
    axi_txn(1'b0, 32'h1010, 32'h0, 4'h0, 3, resp, rd, lat, t0);
    $display("read addr=00001010 data=%h resp=%b lat=%0d", rd, resp, lat);
    total++;
    if (lat != 5 || resp !== 2'b00 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_resp got=lat%0d/%b/%h want=lat5/00/deadbeef", lat, resp, rd);
    end
    total++;
    if (req_count - rc0 != 1 || last_be !== 4'hF || last_we !== 1'b0 || last_addr !== 32'h10) begin
      bad++;
      $display("FAIL rd_ram_fields got=n%0d/%h/%b/%h want=n1/f/0/00000010",
               req_count - rc0, last_be, last_we, last_addr);
    end
    rd0 = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (s_if.rvalid !== 1'b1 || s_if.rdata !== rd0 || s_if.rresp !== 2'b00) begin
        bad++;
        $display("FAIL rd_stall cyc=%0d got=%b/%h want=1/%h", i, s_if.rvalid, s_if.rdata, rd0);
      end
    end
    s_if.rready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (s_if.rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_release got=%b want=0", s_if.rvalid);
    end
  endtask

  task automatic test_decode;
    bit          tw [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ta [9] = '{32'h2000, 32'h0FFC, 32'h0FFF, 32'h1000, 32'h1FFC,
                            32'h1FFF, 32'h1040, 32'h1040, 32'hFFFF_FFFC};
    logic [3:0]  ts [9] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [1:0]  resp;
    logic [31:0] rd, d, exp_rd;
    int          lat, t0, rc0;
    bit          hit;
    for (int i = 0; i < 9; i++) begin
      d      = $urandom;
      hit    = in_win(ta[i]);
      exp_rd = (hit && !tw[i]) ? ref_rd(ta[i]) : 32'h0;
      rc0    = req_count;
      axi_txn(tw[i], ta[i], d, ts[i], 2, resp, rd, lat, t0);
      $display("decode wr=%0d addr=%h resp=%b lat=%0d", tw[i], ta[i], resp, lat);
      total++;
      if (lat != (hit ? 4 : 1) || resp !== (hit ? 2'b00 : 2'b10)) begin
        bad++;
        $display("FAIL decode_resp addr=%h got=lat%0d/%b want=lat%0d/%b",
                 ta[i], lat, resp, hit ? 4 : 1, hit ? 2'b00 : 2'b10);
      end
      total++;
      if (req_count - rc0 != (hit ? 1 : 0)) begin
        bad++; $display("FAIL decode_req addr=%h got=%0d want=%0d", ta[i], req_count - rc0, hit ? 1 : 0);
      end
      if (hit) begin
        total++;
        if (last_addr !== ((ta[i] - 32'h1000) & ~32'h3) || last_be !== (tw[i] ? ts[i] : 4'hF)) begin
          bad++;
          $display("FAIL decode_ram addr=%h got=%h/%h want=%h/%h", ta[i], last_addr, last_be,
                   (ta[i] - 32'h1000) & ~32'h3, tw[i] ? ts[i] : 4'hF);
        end
      end
      if (!tw[i]) begin
        total++;
        if (rd !== exp_rd) begin
          bad++; $display("FAIL decode_rdata addr=%h got=%h want=%h", ta[i], rd, exp_rd);
        end
      end
      if (hit && tw[i]) ref_wr(ta[i], d, ts[i]);
    end
  endtask

  task automatic test_timeout;
    logic [1:0]  resp;
    logic [31:0] rd, d;
    int          lat, t0, rc0;
    ram_mute = 1'b1;
    rc0 = req_count;
    axi_txn(1'b0, 32'h1020, 32'h0, 4'h0, 1, resp, rd, lat, t0);
    ram_mute = 1'b0;
    $display("timeout read resp=%b lat=%0d", resp, lat);
    total++;
    if (lat != 2 + TMO || resp !== 2'b10 || rd !== 32'h0) begin
      bad++;
      $display("FAIL timeout_resp got=lat%0d/%b/%h want=lat%0d/10/0", lat, resp, rd, 2 + TMO);
    end
    total++;
    if (req_count - rc0 != 1) begin
      bad++; $display("FAIL timeout_req got=%0d want=1", req_count - rc0);
    end
    d = $urandom;
    axi_txn(1'b1, 32'h1020, d, 4'hF, 2, resp, rd, lat, t0);
    ref_wr(32'h1020, d, 4'hF);
    total++;
    if (lat != 4 || resp !== 2'b00) begin
      bad++; $display("FAIL after_timeout_wr got=lat%0d/%b want=lat4/00", lat, resp);
    end
    axi_txn(1'b0, 32'h1020, 32'h0, 4'h0, 1, resp, rd, lat, t0);
    total++;
    if (lat != 3 || resp !== 2'b00 || rd !== d) begin
      bad++; $display("FAIL after_timeout_rd got=lat%0d/%b/%h want=lat3/00/%h", lat, resp, rd, d);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat, t0, rc0;
    bit          seen;
    rc0 = req_count;
    @(negedge clk);
    ram_lat = 6;
    s_if.araddr = 32'h1010; s_if.arvalid = 1'b1;
    #1;
    total++;
    if (s_if.arready !== 1'b1) begin
      bad++; $display("FAIL rmid_accept got=%b want=1", s_if.arready);
    end
    @(negedge clk);
    s_if.arvalid = 1'b0;
    @(negedge clk);
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid,
         ram_if.req, ram_if.we} !== 7'b0 || ram_if.addr !== 32'h0 || ram_if.be !== 4'h0) begin
      bad++;
      $display("FAIL rmid_zero got=%b/%h/%h want=0",
               {s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid, ram_if.req, ram_if.we},
               ram_if.addr, ram_if.be);
    end
    @(negedge clk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (s_if.bvalid || s_if.rvalid || ram_if.req) seen = 1'b1;
    end
    total++;
    if (seen || req_count - rc0 != 1) begin
      bad++; $display("FAIL rmid_quiet got=activity%0d/n%0d want=0/n1", seen, req_count - rc0);
    end
    axi_txn(1'b0, 32'h1010, 32'h0, 4'h0, 1, resp, rd, lat, t0);
    $display("post-reset read data=%h resp=%b lat=%0d", rd, resp, lat);
    total++;
    if (rd !== ref_rd(32'h1010) || resp !== 2'b00 || lat != 3) begin
      bad++;
      $display("FAIL rmid_read got=%h/%b/lat%0d want=%h/00/lat3", rd, resp, lat, ref_rd(32'h1010));
    end
  endtask

  task automatic test_random;
    logic [1:0]  resp;
    logic [31:0] rd, a, d, exp_rd;
    logic [3:0]  s;
    int          lat, t0, rc0, l;
    bit          wr, hit;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'hFFF);
        1:       a = 32'h2000 + $urandom_range(0, 32'hFFFF);
        default: a = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      endcase
      d      = $urandom;
      s      = 4'($urandom_range(0, 15));
      l      = $urandom_range(1, 4);
      hit    = in_win(a);
      exp_rd = (hit && !wr) ? ref_rd(a) : 32'h0;
      rc0    = req_count;
      axi_txn(wr, a, d, s, l, resp, rd, lat, t0);
      $display("txn %0d wr=%0d addr=%h strb=%h lat=%0d resp=%b rdata=%h", i, wr, a, s, lat, resp, rd);
      total++;
      if (lat != (hit ? 2 + l : 1) || resp !== (hit ? 2'b00 : 2'b10)) begin
        bad++;
        $display("FAIL rnd_resp txn=%0d got=lat%0d/%b want=lat%0d/%b",
                 i, lat, resp, hit ? 2 + l : 1, hit ? 2'b00 : 2'b10);
      end
      total++;
      if (req_count - rc0 != (hit ? 1 : 0)) begin
        bad++; $display("FAIL rnd_req txn=%0d got=%0d want=%0d", i, req_count - rc0, hit ? 1 : 0);
      end
      if (hit) begin
        total++;
        if (last_addr !== ((a - 32'h1000) & ~32'h3) || last_we !== wr ||
            last_be !== (wr ? s : 4'hF) || last_req_cyc != t0 + 1) begin
          bad++;
          $display("FAIL rnd_ram txn=%0d got=%h/%b/%h@%0d want=%h/%b/%h@%0d", i,
                   last_addr, last_we, last_be, last_req_cyc,
                   (a - 32'h1000) & ~32'h3, wr, wr ? s : 4'hF, t0 + 1);
        end
      end
      if (!wr) begin
        total++;
        if (rd !== exp_rd) begin
          bad++; $display("FAIL rnd_rdata txn=%0d got=%h want=%h", i, rd, exp_rd);
        end
      end
      if (hit && wr) ref_wr(a, d, s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.awaddr = 32'h0; s_if.awvalid = 1'b0;
    s_if.wdata  = 32'h0; s_if.wstrb   = 4'h0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b1;
    s_if.araddr = 32'h0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b1;
    test_reset();
    test_arbitration();
    test_write_read();
    test_decode();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
